indicator_bar_driver: RTL and testbench

- Consumer end of the position stream produced by the PCM-to-position stage.
- Accepts indicator positions over a valid/ready handshake and keeps a ballistic bar level: instant attack, timed decay.
- Tracks a peak marker with hold time and its own decay.
- Drives a registered thermometer-plus-peak-dot segment vector to the LED bar.

---
 rtl/indicator_bar_driver.sv | 187 ++++++++++++++++++
 tb/tb_indicator_bar_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/indicator_bar_driver.sv
// indicator_bar_driver
//   Consumer end of the position stream. Accepts one indicator position per
//   valid/ready transfer. Keeps a ballistic bar level with instant attack and
//   timed decay, plus a peak marker with a hold time and its own decay. Drives
//   a registered thermometer-plus-peak-dot vector to the LED bar.
//
// Ports
//   Clock     in   system clock
//   Reset     in   asynchronous, active-high reset
//   i_valid   in   upstream position valid
//   i_ready   out  block can accept a position (low one cycle per transfer)
//   position  in   [4:0] indicator position, 0 = silent, clamped to SEGMENTS
//   level     out  [4:0] current bar level, 0..SEGMENTS
//   peak      out  [4:0] current peak position, never below level
//   segments  out  [SEGMENTS-1:0] bar drive, bit 0 = lowest segment
module indicator_bar_driver #(
  parameter int unsigned SEGMENTS         = 16,
  parameter int unsigned TICK_DIV         = 1000,
  parameter int unsigned DECAY_TICKS      = 4,
  parameter int unsigned HOLD_TICKS       = 50,
  parameter int unsigned PEAK_DECAY_TICKS = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [4:0]          position,
  output logic [4:0]          level,
  output logic [4:0]          peak,
  output logic [SEGMENTS-1:0] segments
);

  // Counter widths, kept at least one bit wide for degenerate parameter values.
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned PW = (PEAK_DECAY_TICKS > 1) ? $clog2(PEAK_DECAY_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_TICKS);
  localparam logic [PW-1:0] PDIV_LAST  = PW'(PEAK_DECAY_TICKS - 1);
  localparam logic [4:0]    SEG_MAX    = 5'(SEGMENTS);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_READY,
    ST_UPDATE
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [4:0]          pos_q, pos_d;
  logic [4:0]          level_q, level_d;
  logic [4:0]          peak_q, peak_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PW-1:0]       pdiv_q, pdiv_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]       decay_cnt_q, decay_cnt_d;
  logic [SEGMENTS-1:0] segments_q, segments_d;

  logic       tick;
  logic       decay_step;
  logic       apply;
  logic [4:0] dec_level;

  // Handshake FSM: WAIT opens the port once after reset, then every accepted
  // position costs one UPDATE cycle with i_ready low.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ready_d = ready_q;
    pos_d   = pos_q;
    unique case (state_q)
      ST_WAIT: begin
        ready_d = 1'b1;
        state_d = ST_READY;
      end
      ST_READY: begin
        if (i_valid && ready_q) begin
          pos_d   = (position > SEG_MAX) ? SEG_MAX : position;
          ready_d = 1'b0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        ready_d = 1'b1;
        state_d = ST_READY;
      end
      default: begin
        ready_d = 1'b0;
        state_d = ST_WAIT;
      end
    endcase
  end

  // Free-running tick prescaler and level decay divider.
  always_comb begin
    tick        = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    decay_cnt_d = decay_cnt_q;
    decay_step  = 1'b0;
    if (tick) begin
      if (decay_cnt_q == DECAY_LAST) begin
        decay_cnt_d = '0;
        decay_step  = 1'b1;
      end else begin
        decay_cnt_d = decay_cnt_q + 1'b1;
      end
    end
  end

  // Level: decay first, then an update can only raise it (instant attack).
  always_comb begin
    apply     = (state_q == ST_UPDATE);
    dec_level = (decay_step && level_q != 5'd0) ? level_q - 5'd1 : level_q;
    level_d   = (apply && pos_q > dec_level) ? pos_q : dec_level;
  end

  // Peak: capture (equality reloads hold), else hold countdown, else stepped
  // decay. The final clamp keeps the marker at or above the new level.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    pdiv_d = pdiv_q;
    if (apply && pos_q >= peak_q) begin
      peak_d = pos_q;
      hold_d = HOLD_INIT;
      pdiv_d = '0;
    end else if (tick) begin
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (pdiv_q == PDIV_LAST) begin
        pdiv_d = '0;
        peak_d = (peak_q != 5'd0) ? peak_q - 5'd1 : 5'd0;
      end else begin
        pdiv_d = pdiv_q + 1'b1;
      end
    end
    if (level_d > peak_d) begin
      peak_d = level_d;
    end
  end

  // Bar image built from the registered level/peak, so it lags them by one cycle.
  always_comb begin
    segments_d = '0;
    for (int unsigned i = 0; i < SEGMENTS; i++) begin
      segments_d[i] = (5'(i) < level_q) ||
                      (peak_q != 5'd0 && 5'(i) == peak_q - 5'd1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  // NOTE: everything here is plain flops (no memory arrays), so every register is cleared by the async reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_WAIT;
      ready_q     <= 1'b0;
      pos_q       <= '0;
      level_q     <= '0;
      peak_q      <= '0;
      hold_q      <= '0;
      pdiv_q      <= '0;
      tick_cnt_q  <= '0;
      decay_cnt_q <= '0;
      segments_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      pos_q       <= pos_d;
      level_q     <= level_d;
      peak_q      <= peak_d;
      hold_q      <= hold_d;
      pdiv_q      <= pdiv_d;
      tick_cnt_q  <= tick_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      segments_q  <= segments_d;
    end
  end

  assign i_ready  = ready_q;
  assign level    = level_q;
  assign peak     = peak_q;
  assign segments = segments_q;

endmodule

// File: tb/tb_indicator_bar_driver.sv
// Self-checking bench for indicator_bar_driver with SEGMENTS=16, TICK_DIV=4,
// DECAY_TICKS=2, HOLD_TICKS=3, PEAK_DECAY_TICKS=1. Each vector row drives
// Reset/i_valid/position, advances n clock edges and then checks all outputs.
// Ticks land on post-release edges 4, 8, 12, ...; level decays on 8, 16, ...
module tb_indicator_bar_driver;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [4:0]  position = 5'd0;
  logic [4:0]  level;
  logic [4:0]  peak;
  logic [15:0] segments;

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  pos;
    int          n;
    logic        ready;
    logic [4:0]  level;
    logic [4:0]  peak;
    logic [15:0] seg;
  } vec_t;

  vec_t main_q[$];
  vec_t post_q[$];

  indicator_bar_driver #(
    .SEGMENTS        (16),
    .TICK_DIV        (4),
    .DECAY_TICKS     (2),
    .HOLD_TICKS      (3),
    .PEAK_DECAY_TICKS(1)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .position(position),
    .level   (level),
    .peak    (peak),
    .segments(segments)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input int idx, input logic r,
                               input logic [4:0] l, input logic [4:0] p,
                               input logic [15:0] s);
    check({name, ".i_ready"}, idx, 32'(i_ready), 32'(r));
    check({name, ".level"}, idx, 32'(level), 32'(l));
    check({name, ".peak"}, idx, 32'(peak), 32'(p));
    check({name, ".segments"}, idx, 32'(segments), 32'(s));
  endtask

  task automatic add(inout vec_t q[$], input logic rst, input logic v,
                     input logic [4:0] pos, input int n, input logic r,
                     input logic [4:0] l, input logic [4:0] p, input logic [15:0] s);
    vec_t e;
    e.rst = rst; e.valid = v; e.pos = pos; e.n = n;
    e.ready = r; e.level = l; e.peak = p; e.seg = s;
    q.push_back(e);
  endtask

  task automatic run_row(input string name, input int idx, input vec_t e);
    Reset    = e.rst;
    i_valid  = e.valid;
    position = e.pos;
    repeat (e.n) @(posedge Clock);
    #1;
    check_outputs(name, idx, e.ready, e.level, e.peak, e.seg);
  endtask

  initial begin
    // Comments give the post-release edge each row ends on.
    // Reset held three edges.
    add(main_q, 1, 0, 0,  1, 0, 0,  0,  16'h0000);
    add(main_q, 1, 0, 0,  1, 0, 0,  0,  16'h0000);
    add(main_q, 1, 0, 0,  1, 0, 0,  0,  16'h0000);
    // e1: ready rises; e2: accept 10; e3: level/peak; e4: segments.
    add(main_q, 0, 1, 10, 1, 1, 0,  0,  16'h0000);
    add(main_q, 0, 1, 10, 1, 0, 0,  0,  16'h0000);
    add(main_q, 0, 0, 0,  1, 1, 10, 10, 16'h0000);
    add(main_q, 0, 0, 0,  1, 1, 10, 10, 16'h03FF);
    // Decay: level -1 every 8 edges, peak held 3 ticks then tracks down.
    add(main_q, 0, 0, 0,  3, 1, 10, 10, 16'h03FF); // e7
    add(main_q, 0, 0, 0,  1, 1, 9,  10, 16'h03FF); // e8
    add(main_q, 0, 0, 0,  7, 1, 9,  10, 16'h03FF); // e15
    add(main_q, 0, 0, 0,  1, 1, 8,  9,  16'h03FF); // e16
    add(main_q, 0, 0, 0,  1, 1, 8,  9,  16'h01FF); // e17
    add(main_q, 0, 0, 0,  3, 1, 8,  8,  16'h01FF); // e20
    add(main_q, 0, 0, 0,  1, 1, 8,  8,  16'h00FF); // e21
    add(main_q, 0, 0, 0,  3, 1, 7,  7,  16'h00FF); // e24
    add(main_q, 0, 0, 0,  1, 1, 7,  7,  16'h007F); // e25
    // Back-to-back: 10 then 4 offered next cycle; 4 waits, hold not reloaded.
    add(main_q, 0, 1, 10, 1, 0, 7,  7,  16'h007F); // e26
    add(main_q, 0, 1, 4,  1, 1, 10, 10, 16'h007F); // e27
    add(main_q, 0, 1, 4,  1, 0, 10, 10, 16'h03FF); // e28
    add(main_q, 0, 0, 0,  1, 1, 10, 10, 16'h03FF); // e29
    add(main_q, 0, 0, 0,  2, 1, 10, 10, 16'h03FF); // e31
    add(main_q, 0, 0, 0,  1, 1, 9,  10, 16'h03FF); // e32
    add(main_q, 0, 0, 0,  7, 1, 9,  10, 16'h03FF); // e39
    add(main_q, 0, 0, 0,  1, 1, 8,  9,  16'h03FF); // e40
    add(main_q, 0, 0, 0,  1, 1, 8,  9,  16'h01FF); // e41
    // Clamp 31 -> 16, then position 0 leaves level and peak alone.
    add(main_q, 0, 1, 31, 1, 0, 8,  9,  16'h01FF); // e42
    add(main_q, 0, 0, 0,  1, 1, 16, 16, 16'h01FF); // e43
    add(main_q, 0, 0, 0,  1, 1, 16, 16, 16'hFFFF); // e44
    add(main_q, 0, 1, 0,  1, 0, 16, 16, 16'hFFFF); // e45
    add(main_q, 0, 0, 0,  1, 1, 16, 16, 16'hFFFF); // e46
    add(main_q, 0, 0, 0,  2, 1, 15, 16, 16'hFFFF); // e48
    add(main_q, 0, 0, 0,  1, 1, 15, 16, 16'hFFFF); // e49

    // After the mid-UPDATE reset: fresh timeline, 12 discarded, 5 applied,
    // then 5 again (equal to peak) reloads the hold.
    add(post_q, 0, 0, 0,  1,  1, 0, 0, 16'h0000); // e1
    add(post_q, 0, 1, 5,  1,  0, 0, 0, 16'h0000); // e2
    add(post_q, 0, 0, 0,  1,  1, 5, 5, 16'h0000); // e3
    add(post_q, 0, 0, 0,  1,  1, 5, 5, 16'h001F); // e4
    add(post_q, 0, 1, 5,  1,  0, 5, 5, 16'h001F); // e5
    add(post_q, 0, 0, 0,  1,  1, 5, 5, 16'h001F); // e6
    add(post_q, 0, 0, 0,  10, 1, 3, 5, 16'h001F); // e16
    add(post_q, 0, 0, 0,  4,  1, 3, 4, 16'h0017); // e20

    #1;
    check_outputs("reset_initial", 0, 0, 0, 0, 16'h0000);

    foreach (main_q[i]) run_row("main", i, main_q[i]);

    // Reset lands in the UPDATE cycle of a position=12 transfer.
    Reset    = 1'b0;
    i_valid  = 1'b1;
    position = 5'd12;
    @(posedge Clock);
    #1;
    check("abort_accept.i_ready", 0, 32'(i_ready), 32'd0);
    Reset = 1'b1;
    #1;
    check_outputs("abort_now", 0, 0, 0, 0, 16'h0000);
    i_valid  = 1'b0;
    position = 5'd0;
    repeat (2) @(posedge Clock);
    #1;
    check_outputs("abort_held", 0, 0, 0, 0, 16'h0000);

    foreach (post_q[i]) run_row("post_reset", i, post_q[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
